// File: rtl/ysyx_22040088_pc_reg_if.sv
// ysyx_22040088_pc_reg_if
//   Bundle between the IFU and the program-counter register.
//   pc_src      : next PC, driven by the IFU and loaded on every edge
//   pc_out      : current registered PC
//   pc_valid    : low while in reset, high from the first loading edge
//   pc_snpc     : pc_out + 4, wraps modulo 2^XLEN
//   pc_misalign : pc_out[1:0] != 0
//   master = IFU side, slave = PC register side.
interface ysyx_22040088_pc_reg_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] pc_src;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic [XLEN-1:0] pc_snpc;
  logic            pc_misalign;

  modport master (
    output pc_src,
    input  pc_out, pc_valid, pc_snpc, pc_misalign
  );

  modport slave (
    input  pc_src,
    output pc_out, pc_valid, pc_snpc, pc_misalign
  );
endinterface

// File: rtl/ysyx_22040088_pc_reg.sv
// ysyx_22040088_pc_reg
//   Program-counter register for the NPC fetch unit. Loads pc_src on every
//   rising edge (no enable; the IFU holds the PC by feeding pc_out back) and
//   publishes the sequential next PC and a misalignment flag for fetch/debug.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-low reset; forces pc_out = RESET_PC at once
//     bus  : slave side of ysyx_22040088_pc_reg_if (pc_src in; pc_out,
//            pc_valid, pc_snpc, pc_misalign out)
module ysyx_22040088_pc_reg #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22040088_pc_reg_if.slave        bus
);

  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic [XLEN-1:0] w_snpc;
  logic            w_misalign;

  // pc_src is stored as given: low bits are never masked, so a misaligned
  // target is kept and only reported through pc_misalign.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= bus.pc_src;
      r_valid <= 1'b1;
    end
  end

  // Derived from the register only, so the IFU may drive pc_src from
  // pc_snpc without closing a combinational loop. Carry out is dropped.
  assign w_snpc     = r_pc + XLEN'(4);
  assign w_misalign = |r_pc[1:0];

  assign bus.pc_out      = r_pc;
  assign bus.pc_valid    = r_valid;
  assign bus.pc_snpc     = w_snpc;
  assign bus.pc_misalign = w_misalign;

endmodule

// File: tb/tb_ysyx_22040088_pc_reg.sv
// tb_ysyx_22040088_pc_reg
//   Directed bench for the PC register: reset state, sequential fetch, jump,
//   asynchronous mid-run reset, wrap-around of pc_snpc and misalignment.
module tb_ysyx_22040088_pc_reg;
  localparam int XLEN = 64;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ysyx_22040088_pc_reg_if #(.XLEN(XLEN)) bus ();

  ysyx_22040088_pc_reg #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive pc_src after the falling edge, let one rising edge load it, then
  // come back to the falling edge for checking.
  task automatic step(input logic [63:0] src);
    bus.pc_src = src;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [63:0] seq_exp [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    seq_exp[0] = 64'h0000_0000_8000_0004;
    seq_exp[1] = 64'h0000_0000_8000_0008;
    seq_exp[2] = 64'h0000_0000_8000_000C;
    seq_exp[3] = 64'h0000_0000_8000_0010;

    // Power-up reset with clock running and a non-trivial pc_src.
    rst = 1'b0;
    bus.pc_src = 64'hDEAD_BEEF_0000_1230;
    repeat (3) @(negedge clk);
    chk("rst_pc_out",   bus.pc_out,      64'h0000_0000_8000_0000);
    chk("rst_valid",    64'(bus.pc_valid), 64'd0);
    chk("rst_snpc",     bus.pc_snpc,     64'h0000_0000_8000_0004);
    chk("rst_misalign", 64'(bus.pc_misalign), 64'd0);

    // Release between edges, then sequential fetch from pc_snpc.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(bus.pc_snpc);
      chk($sformatf("seq_pc_%0d", i), bus.pc_out, seq_exp[i]);
      chk($sformatf("seq_valid_%0d", i), 64'(bus.pc_valid), 64'd1);
    end

    // Jump, then sequential step from the target.
    step(64'h8000_1234_5678_9AB0);
    chk("jump_pc", bus.pc_out, 64'h8000_1234_5678_9AB0);
    step(bus.pc_snpc);
    chk("jump_next_pc", bus.pc_out, 64'h8000_1234_5678_9AB4);

    // Asynchronous reset between edges.
    step(64'h0000_0000_8000_0040);
    chk("pre_arst_pc", bus.pc_out, 64'h0000_0000_8000_0040);
    bus.pc_src = 64'h1111_2222_3333_4444;
    #2 rst = 1'b0;
    #1;
    chk("arst_pc",    bus.pc_out, 64'h0000_0000_8000_0000);
    chk("arst_valid", 64'(bus.pc_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("arst_hold_pc", bus.pc_out, 64'h0000_0000_8000_0000);
    rst = 1'b1;
    step(64'h0000_0000_8000_0100);
    chk("release_pc",    bus.pc_out, 64'h0000_0000_8000_0100);
    chk("release_valid", 64'(bus.pc_valid), 64'd1);

    // Wrap-around of the sequential PC.
    step(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc",   bus.pc_out,  64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_snpc", bus.pc_snpc, 64'h0);
    step(bus.pc_snpc);
    chk("wrap_next_pc",   bus.pc_out,  64'h0);
    chk("wrap_next_snpc", bus.pc_snpc, 64'h4);

    // Misaligned PC is held unmasked and flagged.
    step(64'h0000_0000_8000_0002);
    chk("mis_pc",       bus.pc_out, 64'h0000_0000_8000_0002);
    chk("mis_flag",     64'(bus.pc_misalign), 64'd1);
    chk("mis_snpc",     bus.pc_snpc, 64'h0000_0000_8000_0006);
    step(64'h0000_0000_8000_0004);
    chk("aligned_pc",   bus.pc_out, 64'h0000_0000_8000_0004);
    chk("aligned_flag", 64'(bus.pc_misalign), 64'd0);
    step(64'h0000_0000_8000_0001);
    chk("mis_bit0_flag", 64'(bus.pc_misalign), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
